// File: rtl/vend_txn_ctrl.sv
// vend_txn_ctrl: vend transaction sequencer driving port B of the inventory RAM.
// Each accepted request reads the stock and price words, decides
// OK / SOLD_OUT / NO_CREDIT / BAD_ITEM, writes back the decremented stock on OK
// and reports status and change with a one-cycle done pulse.
// The RAM has a registered q, so read data appears one cycle after the address.
// Every output is registered, including ram_addr, ram_wdata and ram_we.
// Optional feature: define LOW_STOCK_ALARM_EN to add the low_stock output. It
// pulses with done when an OK vend leaves stock <= LOW_STOCK_THRESH.
module vend_txn_ctrl #(
    parameter int DATA_WIDTH       = 16,
    parameter int ADDR_WIDTH       = 8,
    parameter int NUM_ITEMS        = 4,
    parameter int PRICE_OFFSET     = 16,
    parameter int LOW_STOCK_THRESH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_item,
    input  logic [DATA_WIDTH-1:0] req_credit,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  done,
    output logic [1:0]            status,
    output logic [DATA_WIDTH-1:0] change
`ifdef LOW_STOCK_ALARM_EN
    ,
    output logic                  low_stock
`endif
);

    localparam logic [1:0] ST_OK        = 2'd0;
    localparam logic [1:0] ST_SOLD_OUT  = 2'd1;
    localparam logic [1:0] ST_NO_CREDIT = 2'd2;
    localparam logic [1:0] ST_BAD_ITEM  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_STOCK = 3'd1,
        S_RD_PRICE = 3'd2,
        S_EVAL     = 3'd3,
        S_WRITE    = 3'd4,
        S_RESP     = 3'd5
    } state_t;

    state_t                state_r;
    state_t                state_s;

    logic [ADDR_WIDTH-1:0] item_r;
    logic [DATA_WIDTH-1:0] credit_r;
    logic [DATA_WIDTH-1:0] stock_r;
    logic [DATA_WIDTH-1:0] price_r;
    logic [1:0]            status_pend_r;
    logic [DATA_WIDTH-1:0] change_pend_r;

    logic                  accept_s;
    logic                  bad_item_s;
    logic [1:0]            eval_status_s;

    logic                  req_ready_s;
    logic [ADDR_WIDTH-1:0] ram_addr_s;
    logic [DATA_WIDTH-1:0] ram_wdata_s;
    logic                  ram_we_s;
    logic                  done_s;
    logic [1:0]            status_s;
    logic [DATA_WIDTH-1:0] change_s;
`ifdef LOW_STOCK_ALARM_EN
    logic                  low_stock_s;
`endif

    // Handshake and item range check; req_ready is the registered IDLE flag.
    always_comb begin
        accept_s   = req_valid & req_ready;
        bad_item_s = (req_item >= ADDR_WIDTH'(NUM_ITEMS));
    end

    // Vend decision made in EVAL, where ram_rdata carries the price.
    always_comb begin
        eval_status_s = ST_OK;
        if (stock_r == {DATA_WIDTH{1'b0}}) begin
            eval_status_s = ST_SOLD_OUT;
        end else if (credit_r < ram_rdata) begin
            eval_status_s = ST_NO_CREDIT;
        end else begin
            eval_status_s = ST_OK;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic. WRITE is always visited so that latency is fixed.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    if (bad_item_s) begin
                        state_s = S_RESP;
                    end else begin
                        state_s = S_RD_STOCK;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_RD_STOCK: state_s = S_RD_PRICE;
            S_RD_PRICE: state_s = S_EVAL;
            S_EVAL:     state_s = S_WRITE;
            S_WRITE:    state_s = S_RESP;
            S_RESP:     state_s = S_IDLE;
            default:    state_s = S_IDLE;
        endcase
    end

    // Next values of the registered outputs, keyed on the state being entered.
    always_comb begin
        req_ready_s = (state_s == S_IDLE);
        ram_addr_s  = {ADDR_WIDTH{1'b0}};
        ram_wdata_s = {DATA_WIDTH{1'b0}};
        ram_we_s    = 1'b0;
        case (state_s)
            S_RD_STOCK: begin
                // Only entered from IDLE on accept, so req_item is the item.
                ram_addr_s = req_item;
            end
            S_RD_PRICE: begin
                ram_addr_s = item_r + ADDR_WIDTH'(PRICE_OFFSET);
            end
            S_WRITE: begin
                // Only entered from EVAL, so eval_status_s is this vend's decision.
                ram_addr_s  = item_r;
                ram_wdata_s = stock_r - DATA_WIDTH'(1);
                ram_we_s    = (eval_status_s == ST_OK);
            end
            default: begin
                ram_addr_s = {ADDR_WIDTH{1'b0}};
            end
        endcase

        if (state_r == S_RESP) begin
            done_s   = 1'b1;
            status_s = status_pend_r;
            change_s = change_pend_r;
        end else begin
            done_s   = 1'b0;
            status_s = status;
            change_s = change;
        end
    end

`ifdef LOW_STOCK_ALARM_EN
    // Low-stock alarm accompanies done for an OK vend that leaves stock at or below threshold.
    always_comb begin
        if ((state_r == S_RESP) && (status_pend_r == ST_OK) &&
            ((stock_r - DATA_WIDTH'(1)) <= DATA_WIDTH'(LOW_STOCK_THRESH))) begin
            low_stock_s = 1'b1;
        end else begin
            low_stock_s = 1'b0;
        end
    end
`endif

    // Transaction datapath: latch the request, then stock, price, decision and change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            item_r        <= {ADDR_WIDTH{1'b0}};
            credit_r      <= {DATA_WIDTH{1'b0}};
            stock_r       <= {DATA_WIDTH{1'b0}};
            price_r       <= {DATA_WIDTH{1'b0}};
            status_pend_r <= ST_OK;
            change_pend_r <= {DATA_WIDTH{1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        item_r        <= req_item;
                        credit_r      <= req_credit;
                        status_pend_r <= bad_item_s ? ST_BAD_ITEM : ST_OK;
                        change_pend_r <= req_credit;
                    end
                end
                S_RD_PRICE: begin
                    stock_r <= ram_rdata;
                end
                S_EVAL: begin
                    price_r       <= ram_rdata;
                    status_pend_r <= eval_status_s;
                end
                S_WRITE: begin
                    change_pend_r <= (status_pend_r == ST_OK) ? (credit_r - price_r) : credit_r;
                end
                default: begin
                    change_pend_r <= change_pend_r;
                end
            endcase
        end
    end

    // Output registers; reset drops ram_we immediately and leaves the block ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready <= 1'b1;
            ram_addr  <= {ADDR_WIDTH{1'b0}};
            ram_wdata <= {DATA_WIDTH{1'b0}};
            ram_we    <= 1'b0;
            done      <= 1'b0;
            status    <= ST_OK;
            change    <= {DATA_WIDTH{1'b0}};
        end else begin
            req_ready <= req_ready_s;
            ram_addr  <= ram_addr_s;
            ram_wdata <= ram_wdata_s;
            ram_we    <= ram_we_s;
            done      <= done_s;
            status    <= status_s;
            change    <= change_s;
        end
    end

`ifdef LOW_STOCK_ALARM_EN
    // Registered low-stock pulse, aligned with done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            low_stock <= 1'b0;
        end else begin
            low_stock <= low_stock_s;
        end
    end
`endif

endmodule
